// File: rtl/pll_phase_pkg.sv
// Shared types and helpers for the PLL dynamic phase-shift sequencer.
package pll_phase_pkg;

    localparam int unsigned SEL_W    = 2;
    localparam int unsigned PLAN_N_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        GAP,
        DONE,
        ABORT
    } state_t;

    typedef struct packed {
        logic                dir;
        logic [PLAN_N_W-1:0] n;
    } step_plan_t;

    // Shortest modular walk from cur to target; a half-period tie goes the delay way.
    function automatic step_plan_t shortest_step(input int unsigned cur,
                                                 input int unsigned target,
                                                 input int unsigned steps);
        step_plan_t  plan;
        int unsigned delta;
        delta = (target - cur) & (steps - 1);
        if (delta <= steps / 2) begin
            plan.dir = 1'b0;
            plan.n   = PLAN_N_W'(delta);
        end else begin
            plan.dir = 1'b1;
            plan.n   = PLAN_N_W'(steps - delta);
        end
        return plan;
    endfunction

endpackage

// File: rtl/pll_phase_ctrl.sv
// Drives EHXPLLL dynamic phase-shift pins from absolute per-channel phase targets,
// tracking each channel's current phase and stepping the shortest way round.
module pll_phase_ctrl #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned PHASE_STEPS = 8,
    parameter int unsigned PHASE_W     = $clog2(PHASE_STEPS),
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned STEP_CYC    = 1,
    parameter int unsigned GAP_CYC     = 1,
    parameter int unsigned SEL_OFFSET  = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          locked,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [1:0]                    req_ch,
    input  logic [PHASE_W-1:0]            req_phase,
    output logic                          done,
    output logic                          err,
    output logic                          busy,
    output logic [CHANNELS*PHASE_W-1:0]   phase_cur,
    output logic [1:0]                    phasesel,
    output logic                          phasedir,
    output logic                          phasestep,
    output logic                          phaseloadreg
);
    import pll_phase_pkg::*;

    localparam int unsigned MAX_A   = (SETUP_CYC > STEP_CYC) ? SETUP_CYC : STEP_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SEL_W-1:0]     ch_q, ch_d;
    logic                 dir_q, dir_d;
    logic [PHASE_W-1:0]   n_q, n_d;
    logic                 lost_q, lost_d;
    logic [PHASE_W-1:0]   phase_q [CHANNELS];
    logic [PHASE_W-1:0]   phase_d [CHANNELS];
    logic [SEL_W-1:0]     phasesel_q, phasesel_d;
    logic                 phasedir_q, phasedir_d;
    logic                 phasestep_q, phasestep_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 lock_meta_q, locked_s_q;

    logic                 accept;
    logic                 ch_ok;
    logic [PHASE_W-1:0]   cur;
    step_plan_t           plan;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            locked_s_q  <= 1'b0;
        end else begin
            lock_meta_q <= locked;
            locked_s_q  <= lock_meta_q;
        end
    end

    assign req_ready = (state_q == IDLE) && locked_s_q;
    assign accept    = req_valid && req_ready;
    assign ch_ok     = ({30'b0, req_ch} < 32'(CHANNELS));

    always_comb begin
        cur = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            if (req_ch == SEL_W'(k)) cur = phase_q[k];
        end
        plan = shortest_step(32'(cur), 32'(req_phase), PHASE_STEPS);
    end

    // Next-state and output logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        dir_d      = dir_q;
        n_d        = n_q;
        lost_d     = lost_q;
        phase_d    = phase_q;
        phasesel_d = phasesel_q;
        phasedir_d = phasedir_q;

        case (state_q)
            IDLE: begin
                lost_d = 1'b0;
                if (accept) begin
                    ch_d = req_ch;
                    if (!ch_ok || plan.n == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = SETUP;
                        cnt_d      = CNT_W'(SETUP_CYC - 1);
                        dir_d      = plan.dir;
                        n_d        = PHASE_W'(plan.n);
                        phasesel_d = SEL_W'(32'(req_ch) + SEL_OFFSET);
                        phasedir_d = plan.dir;
                    end
                end
            end
            SETUP: begin
                if (!locked_s_q) begin
                    state_d = ABORT;
                end else if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = CNT_W'(STEP_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PULSE: begin
                // A started pulse always runs its full width; lock loss is deferred.
                if (!locked_s_q) lost_d = 1'b1;
                if (cnt_q == '0) begin
                    if (lost_q || !locked_s_q) begin
                        state_d = ABORT;
                    end else begin
                        state_d = GAP;
                        cnt_d   = CNT_W'(GAP_CYC - 1);
                        n_d     = n_q - 1'b1;
                        for (int k = 0; k < int'(CHANNELS); k++) begin
                            if (ch_q == SEL_W'(k)) begin
                                phase_d[k] = dir_q ? phase_q[k] - 1'b1 : phase_q[k] + 1'b1;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (!locked_s_q) begin
                    state_d = ABORT;
                end else if (cnt_q == '0) begin
                    if (n_q != '0) begin
                        state_d = PULSE;
                        cnt_d   = CNT_W'(STEP_CYC - 1);
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Relock resets the PLL output dividers, so tracked phases restart at zero.
        if (!locked_s_q) begin
            for (int k = 0; k < int'(CHANNELS); k++) phase_d[k] = '0;
        end

        phasestep_d = (state_d == PULSE);
        done_d      = (state_d == DONE);
        err_d       = (state_d == ABORT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ch_q        <= '0;
            dir_q       <= 1'b0;
            n_q         <= '0;
            lost_q      <= 1'b0;
            phase_q     <= '{default: '0};
            phasesel_q  <= '0;
            phasedir_q  <= 1'b0;
            phasestep_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ch_q        <= ch_d;
            dir_q       <= dir_d;
            n_q         <= n_d;
            lost_q      <= lost_d;
            phase_q     <= phase_d;
            phasesel_q  <= phasesel_d;
            phasedir_q  <= phasedir_d;
            phasestep_q <= phasestep_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    for (genvar k = 0; k < int'(CHANNELS); k++) begin : g_phase_out
        assign phase_cur[k*PHASE_W +: PHASE_W] = phase_q[k];
    end

    assign phasesel     = phasesel_q;
    assign phasedir     = phasedir_q;
    assign phasestep    = phasestep_q;
    assign done         = done_q;
    assign err          = err_q;
    assign busy         = busy_q;
    assign phaseloadreg = 1'b0;

endmodule

// File: doc/pll_phase_ctrl.md
Name: pll_phase_ctrl

Overview:
- Sequencer that drives the ECP5 EHXPLLL dynamic phase-shift pins (PHASESEL, PHASEDIR, PHASESTEP, PHASELOADREG) from absolute per-channel phase targets.
- Tracks the current phase of each of up to 4 PLL outputs and picks the shortest step direction.
- Generates step pulses with parametrised setup, high and gap times.
- Sits between control logic (DDR/video phase training) and the PLL wrapper's phase ports.

Parameters:
- CHANNELS, 4, number of phase-tracked PLL outputs (1..4).
- PHASE_STEPS, 8, phase steps per VCO period; power of two, >= 2.
- PHASE_W, $clog2(PHASE_STEPS), width of a phase value.
- SETUP_CYC, 1, cycles phasesel/phasedir are held stable before the first step pulse (>= 5 ns).
- STEP_CYC, 1, cycles phasestep is high (>= 5 ns).
- GAP_CYC, 1, cycles phasestep is low between pulses.
- SEL_OFFSET, 3, added mod 4 to the channel index to form the hardware phasesel (3 = index-1).

Ports:
- clk  in  1  control clock; all phase outputs are synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- locked  in  1  PLL lock; asynchronous, synchronised with 2 flops internally.
- req_valid  in  1  request strobe.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_ch  in  2  logical channel; values >= CHANNELS are ignored (done without pulses).
- req_phase  in  PHASE_W  absolute target phase, in steps of lag.
- done  out  1  one-cycle pulse at request completion.
- err  out  1  one-cycle pulse when a request is aborted by loss of lock.
- busy  out  1  high when not IDLE.
- phase_cur  out  CHANNELS*PHASE_W  current phase per channel; channel k is at bits [k*PHASE_W +: PHASE_W].
- phasesel  out  2  to the PLL PHASESEL[1:0].
- phasedir  out  1  to the PLL PHASEDIR; 0 = delay, 1 = advance.
- phasestep  out  1  to the PLL PHASESTEP; applied on its falling edge.
- phaseloadreg  out  1  to the PLL PHASELOADREG; held 0.

Behaviour:
- Reset: all outputs 0, all phase_cur 0, state IDLE.
- req_ready = (state==IDLE) && locked_s.
- Accept: latch ch, target and cur = phase_cur[ch].
  - delta = (target - cur) mod PHASE_STEPS.
  - delta == 0: go to DONE, no pulses.
  - delta <= PHASE_STEPS/2: dir=0 (delay), n = delta.
  - Otherwise: dir=1 (advance), n = PHASE_STEPS - delta.
  - A tie at PHASE_STEPS/2 resolves to delay.
- States:
  - IDLE -> SETUP on accept. Drive phasesel = (ch + SEL_OFFSET) mod 4 and phasedir = dir; both stay stable until DONE.
  - SETUP: count SETUP_CYC cycles -> PULSE.
  - PULSE: phasestep=1 for STEP_CYC cycles -> GAP.
  - GAP: phasestep=0 for GAP_CYC cycles.
    - On GAP entry (the falling edge): phase_cur[ch] += 1 (delay) or -= 1 (advance), mod PHASE_STEPS; n -= 1.
    - At GAP end: n != 0 -> PULSE; n == 0 -> DONE.
  - DONE: done=1 for 1 cycle -> IDLE.
- Latency from accept to done: SETUP_CYC + n*(STEP_CYC+GAP_CYC) + 1 cycles. For delta == 0: done on the cycle after accept.
- Phase wrap-around is modular; phase_cur never leaves 0..PHASE_STEPS-1.
- Loss of lock (locked_s falls):
  - All phase_cur are cleared to 0 immediately, because PLL relock resets the output dividers.
  - If in PULSE: finish the current STEP_CYC, then go to ABORT (the falling edge is still legal; no phase update).
  - If in SETUP or GAP: go to ABORT next cycle.
  - ABORT: phasestep=0, err=1 for 1 cycle, no done -> IDLE.
  - Simultaneous lock loss and accept: the request is not accepted.
- Asynchronous reset mid-operation: phasestep drops to 0 immediately; all state returns to reset values.

Decomposition:
- Package pll_phase_pkg:
  - state enum {IDLE, SETUP, PULSE, GAP, DONE, ABORT}.
  - Function for the shortest modular distance (returns dir, n).
  - Constant SEL_W=2.
- Single module; no sub-module. The 2-flop lock synchroniser stays inline.

Test Plan (all with defaults):
- Reset, then locked=1 after 10 cycles -> all outputs 0 during reset; req_ready=1 two cycles after locked rises; phase_cur=0.
- ch1 target 3 from 0 -> phasesel=0, phasedir=0, 3 phasestep pulses (1 high / 1 low), done 8 cycles after accept, phase_cur[1]=3.
- ch2 target 6 from 0 -> phasesel=1, phasedir=1, 2 pulses, phase_cur[2]=6, done 6 cycles after accept.
- ch1 at 3, target 3 -> no pulse, done on the next cycle; ch0 target 4 from 0 (tie) -> phasesel=3, dir=0, 4 pulses.
- ch3 target 2, locked=0 during the first PULSE -> that pulse completes, err pulse, no done, all phase_cur=0, no further pulses, req_ready=0 until relock.
- req_ch=3 with CHANNELS=2 -> no pulses, done next cycle; rst_n asserted mid-PULSE -> phasestep=0 in the same cycle.
